lsu_pl: RTL
===========

# lsu_pl

Pipelined, parametrised load/store unit for the RV32I pipelined core: serves the MEM stage through a valid/ready request/response handshake. Backs a byte-enabled synchronous data RAM and memory-mapped I/O: LEDR, LEDG, HEX digits, LCD and switches. Provides 1-cycle load latency, full throughput and explicit fault reporting. Replaces the combinational-read, fixed-size LSU.

## Interface
- RAM_DEPTH_WORDS, 512, data RAM depth in 32-bit words; power of 2, 64..16384
- NUM_HEX, 8, number of 7-segment digits; 4 or 8
- SW_W, 32, switch input width; 1..32, zero-extended on read
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-low reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted when valid&&ready
- i_req_we  in  1  1 = store, 0 = load
- i_req_addr  in  32  byte address
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_req_unsigned  in  1  zero-extend sub-word loads
- i_req_wdata  in  32  store data, right-aligned
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed when valid&&ready
- o_rsp_rdata  out  32  load data, extended; 0 for stores/faults
- o_rsp_fault  out  1  request faulted, no side effect
- o_rsp_cause  out  2  0 none, 1 misaligned/illegal size, 2 unmapped, 3 write to read-only
- o_io_ledr  out  32  red LED register
- o_io_ledg  out  32  green LED register
- o_io_hex  out  7*NUM_HEX  digit k at [7k+6:7k]
- o_io_lcd  out  32  LCD control register
- i_io_sw  in  SW_W  switches

## Operation
- Address map:
  - RAM at 0x0000_0000 up to RAM_DEPTH_WORDS*4-1.
  - LEDR 0x1000_0xxx; LEDG 0x1000_1xxx.
  - HEX0-3 0x1000_2xxx; HEX4-7 0x1000_3xxx, unmapped if NUM_HEX=4.
  - LCD 0x1000_4xxx; SW 0x1001_0xxx, read-only.
  - Everything else is unmapped.
- Byte lanes come from size and addr[1:0]; register offset within a region is ignored.
- Priority of checks: misaligned first (half with addr[0]=1, word with addr[1:0]!=0, size 11); then unmapped; then store to SW.
- A faulted access writes nothing and returns rdata 0.
- Stores: only the selected lanes are written.
  - RAM: byte-enable write.
  - LEDR/LEDG/LCD: per-lane update.
  - HEX: lane j writes digit (4*region_index + j) from bits [8j+6:8j].
- Loads: lane extracted, then sign- or zero-extended per i_req_unsigned; word loads ignore i_req_unsigned.
  - HEX read word is {1'b0,d3,1'b0,d2,1'b0,d1,1'b0,d0} of the addressed group.
  - SW read is zero-extended.
- Response state: single register slot (EMPTY/FULL).
  - EMPTY→FULL on accept.
  - FULL→FULL on accept && i_rsp_ready.
  - FULL→EMPTY on i_rsp_ready without accept.
- Reset:
  - o_rsp_valid=0, o_rsp_rdata=0, o_rsp_fault=0, o_rsp_cause=0.
  - LEDR, LEDG, LCD and all HEX registers = 0.
  - RAM contents are not cleared.
- Reset mid-operation: a pending response is dropped; a store accepted in the same cycle as reset is not committed.

## Timing
- o_req_ready = !o_rsp_valid || i_rsp_ready; it is combinational from i_rsp_ready only, never from i_req_valid.
- Store commits at the accepting clock edge; its response is valid the next cycle.
- Load latency: 1 cycle. RAM is read at the accepting edge, formatting is registered, and o_rsp_rdata is valid the cycle after accept.
- Throughput: one request per cycle while i_rsp_ready=1.
- Store then load to the same address back-to-back: the load returns the new data (write-first RAM).
- Response outputs hold stable while o_rsp_valid && !i_rsp_ready.
- I/O registers are sampled at the accepting edge.

## Configuration
- LSU_SW_SYNC_EN defined: i_io_sw passes through a two-flop synchroniser, reset to 0.
  - Loads return the synchronised value, 2 cycles behind the pin.
- LSU_SW_SYNC_EN undefined: i_io_sw is sampled directly at the accepting edge.

## Structure
- lsu_pkg holds:
  - size_e, cause_e.
  - Region base/mask localparams.
  - Function decode_region(addr) returning a region enum.
  - Functions lane_mask(size, addr) and load_extend(word, size, addr, unsigned).
- Sub-module lsu_ram: single-port, synchronous, write-first, 4-bit byte-enable, parameter DEPTH.

## Test plan
- sw 0xDEADBEEF to 0x10; then lb, lbu, lh, lhu, lw of 0x13/0x13/0x12/0x12/0x10:
  - rdata 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD, 0xDEADBEEF.
  - Each response arrives exactly 1 cycle after accept.
- Back-to-back sb 0x55 to 0x21, then lw 0x20 on the next cycle with i_rsp_ready=1:
  - Second response rdata has byte 1 = 0x55.
  - o_req_ready stays 1 throughout.
- lw 0x22 -> fault, cause 1, rdata 0; RAM is unchanged.
  - sw 0x2000_0000 -> cause 2.
  - sw 0x1001_0000 -> cause 3.
- sb 0x3F to 0x1000_2002 -> o_io_hex[20:14]=0x3F with other digits 0; lw 0x1000_2000 -> 0x003F0000.
- i_rsp_ready=0 for 3 cycles after a load:
  - o_req_ready=0 and the response is held stable.
  - A new request is accepted in the cycle i_rsp_ready rises.
- Assert reset with a response pending and LEDR=0x1234:
  - Next cycle o_rsp_valid=0 and o_io_ledr=0.
  - An earlier RAM word still reads back intact.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, address map and lane helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_UNMAPPED = 2'd2,
        CAUSE_READONLY = 2'd3
    } cause_e;

    typedef enum logic [2:0] {
        RG_RAM,
        RG_LEDR,
        RG_LEDG,
        RG_HEX_LO,
        RG_HEX_HI,
        RG_LCD,
        RG_SW,
        RG_NONE
    } region_e;

    localparam logic [31:0] PAGE_MASK   = 32'hFFFF_F000;
    localparam logic [31:0] LEDR_BASE   = 32'h1000_0000;
    localparam logic [31:0] LEDG_BASE   = 32'h1000_1000;
    localparam logic [31:0] HEX_LO_BASE = 32'h1000_2000;
    localparam logic [31:0] HEX_HI_BASE = 32'h1000_3000;
    localparam logic [31:0] LCD_BASE    = 32'h1000_4000;
    localparam logic [31:0] SW_BASE     = 32'h1001_0000;

    function automatic region_e decode_region(input logic [31:0] addr,
                                              input int unsigned ram_words,
                                              input int unsigned num_hex);
        region_e     rg;
        logic [31:0] page;
        page = addr & PAGE_MASK;
        if (addr < ram_words * 32'd4)  rg = RG_RAM;
        else if (page == LEDR_BASE)    rg = RG_LEDR;
        else if (page == LEDG_BASE)    rg = RG_LEDG;
        else if (page == HEX_LO_BASE)  rg = RG_HEX_LO;
        else if (page == HEX_HI_BASE)  rg = (num_hex == 32'd8) ? RG_HEX_HI : RG_NONE;
        else if (page == LCD_BASE)     rg = RG_LCD;
        else if (page == SW_BASE)      rg = RG_SW;
        else                           rg = RG_NONE;
        return rg;
    endfunction

    function automatic logic misaligned(input size_e size, input logic [1:0] off);
        return (size == SZ_ILL) || (size == SZ_HALF && off[0]) ||
               (size == SZ_WORD && off != 2'b00);
    endfunction

    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << off;
            SZ_HALF: m = 4'b0011 << {off[1], 1'b0};
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate right-aligned store data so every lane carries its own bytes.
    function automatic logic [31:0] store_align(input size_e size, input logic [31:0] w);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{w[7:0]}};
            SZ_HALF: r = {2{w[15:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input size_e size,
                                                input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: r = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: r = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_ram.sv
// rtl/lsu_ram.sv - single-port synchronous write-first data RAM with byte enables
module lsu_ram #(
    parameter int DEPTH = 512
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [3:0]               be_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i && be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    rdata_q[8*b +: 8]       <= wdata_i[8*b +: 8];
                end else begin
                    rdata_q[8*b +: 8]       <= mem_q[addr_i][8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/lsu_pl.sv
// rtl/lsu_pl.sv - pipelined load/store unit with RAM and MMIO; LSU_SW_SYNC_EN adds a switch synchroniser
module lsu_pl
    import lsu_pkg::*;
#(
    parameter int RAM_DEPTH_WORDS = 512,
    parameter int NUM_HEX         = 8,
    parameter int SW_W            = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [31:0]          i_req_addr,
    input  logic [1:0]           i_req_size,
    input  logic                 i_req_unsigned,
    input  logic [31:0]          i_req_wdata,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [31:0]          o_rsp_rdata,
    output logic                 o_rsp_fault,
    output logic [1:0]           o_rsp_cause,
    output logic [31:0]          o_io_ledr,
    output logic [31:0]          o_io_ledg,
    output logic [7*NUM_HEX-1:0] o_io_hex,
    output logic [31:0]          o_io_lcd,
    input  logic [SW_W-1:0]      i_io_sw
);
    localparam int RAM_AW = $clog2(RAM_DEPTH_WORDS);

    typedef enum logic {ST_EMPTY, ST_FULL} state_e;

    state_e      state_q, state_d;
    logic        accept, ok, wr;
    size_e       req_size;
    region_e     region;
    cause_e      cause;
    logic [3:0]  mask;
    logic [31:0] st_data, io_word, sw_ext, ram_rdata;
    logic [SW_W-1:0] sw_val;

    logic [31:0] ledr_q, ledg_q, lcd_q, io_rdata_q;
    logic [6:0]  hex_q [8];
    logic        rsp_fault_q, rsp_load_q, rsp_ram_q, rsp_uns_q;
    cause_e      rsp_cause_q;
    size_e       rsp_size_q;
    logic [1:0]  rsp_off_q;

    assign o_rsp_valid = (state_q == ST_FULL);
    assign o_req_ready = !o_rsp_valid || i_rsp_ready;
    // A request presented during reset is never accepted, so nothing commits.
    assign accept      = i_req_valid && o_req_ready && i_reset;

    assign req_size = size_e'(i_req_size);
    assign region   = decode_region(i_req_addr, RAM_DEPTH_WORDS, NUM_HEX);
    assign mask     = lane_mask(req_size, i_req_addr[1:0]);
    assign st_data  = store_align(req_size, i_req_wdata);

    always_comb begin
        cause = CAUSE_NONE;
        if (misaligned(req_size, i_req_addr[1:0])) cause = CAUSE_MISALIGN;
        else if (region == RG_NONE)                cause = CAUSE_UNMAPPED;
        else if (i_req_we && region == RG_SW)      cause = CAUSE_READONLY;
    end

    assign ok = accept && (cause == CAUSE_NONE);
    assign wr = ok && i_req_we;

    lsu_ram #(.DEPTH(RAM_DEPTH_WORDS)) u_ram (
        .clk_i   (i_clk),
        .en_i    (ok && region == RG_RAM),
        .we_i    (i_req_we),
        .be_i    (mask),
        .addr_i  (i_req_addr[RAM_AW+1:2]),
        .wdata_i (st_data),
        .rdata_o (ram_rdata)
    );

`ifdef LSU_SW_SYNC_EN
    logic [SW_W-1:0] sw_meta_q, sw_sync_q;
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= i_io_sw;
            sw_sync_q <= sw_meta_q;
        end
    end
    assign sw_val = sw_sync_q;
`else
    assign sw_val = i_io_sw;
`endif

    always_comb begin
        sw_ext = '0;
        sw_ext[SW_W-1:0] = sw_val;
    end

    always_comb begin
        io_word = '0;
        case (region)
            RG_LEDR:   io_word = ledr_q;
            RG_LEDG:   io_word = ledg_q;
            RG_LCD:    io_word = lcd_q;
            RG_HEX_LO: io_word = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
            RG_HEX_HI: io_word = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
            RG_SW:     io_word = sw_ext;
            default:   io_word = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            ledr_q <= '0;
            ledg_q <= '0;
            lcd_q  <= '0;
            for (int k = 0; k < 8; k++) hex_q[k] <= '0;
        end else if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) begin
                    case (region)
                        RG_LEDR:   ledr_q[8*b +: 8] <= st_data[8*b +: 8];
                        RG_LEDG:   ledg_q[8*b +: 8] <= st_data[8*b +: 8];
                        RG_LCD:    lcd_q[8*b +: 8]  <= st_data[8*b +: 8];
                        RG_HEX_LO: hex_q[b]         <= st_data[8*b +: 7];
                        RG_HEX_HI: hex_q[4+b]       <= st_data[8*b +: 7];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            io_rdata_q  <= '0;
            rsp_fault_q <= 1'b0;
            rsp_cause_q <= CAUSE_NONE;
            rsp_load_q  <= 1'b0;
            rsp_ram_q   <= 1'b0;
            rsp_uns_q   <= 1'b0;
            rsp_size_q  <= SZ_BYTE;
            rsp_off_q   <= 2'b00;
        end else if (accept) begin
            io_rdata_q  <= io_word;
            rsp_fault_q <= (cause != CAUSE_NONE);
            rsp_cause_q <= cause;
            rsp_load_q  <= !i_req_we && (cause == CAUSE_NONE);
            rsp_ram_q   <= (region == RG_RAM);
            rsp_uns_q   <= i_req_unsigned;
            rsp_size_q  <= req_size;
            rsp_off_q   <= i_req_addr[1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) state_q <= ST_EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (!accept && i_rsp_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Formatting sits after the registered RAM/IO word so it holds steady while stalled.
    assign o_rsp_rdata = rsp_load_q ?
        load_extend(rsp_ram_q ? ram_rdata : io_rdata_q, rsp_size_q, rsp_off_q, rsp_uns_q) : '0;
    assign o_rsp_fault = rsp_fault_q;
    assign o_rsp_cause = rsp_cause_q;

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;

    for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
        assign o_io_hex[7*k +: 7] = hex_q[k];
    end
endmodule
